// File: rtl/glb_bus_pkg.sv
// Shared GLB-to-PE bus definitions, used by the receiver, the GLB transmitter and the PE models.
package glb_bus_pkg;

  typedef enum logic [1:0] {BT_IFMAP, BT_FLTR, BT_PSUM, BT_RSVD} bus_type_e;

  function automatic int id_width(input int num_col);
    return $clog2(num_col);
  endfunction

endpackage

// File: rtl/glb_pe_bus_receiver_if.sv
// GLB-to-PE shared bus: the transmitter drives the word, each PE receiver answers with READY.
interface glb_pe_bus_receiver_if
  import glb_bus_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_COL    = 4
);
  localparam int IDW = id_width(NUM_COL);

  logic                    bus_valid;
  logic [IDW-1:0]          bus_tag;
  logic [1:0]              bus_type;
  logic [2*DATA_WIDTH-1:0] bus_data;
  logic                    bus_ready;

  modport master (output bus_valid, bus_tag, bus_type, bus_data, input bus_ready);
  modport slave  (input bus_valid, bus_tag, bus_type, bus_data, output bus_ready);
endinterface

// File: rtl/glb_sync_fifo.sv
// First-word-fall-through sync FIFO; full/empty come from the registered count only.
module glb_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] r_mem;
  logic [AW-1:0]               r_wr, r_rd;
  logic [AW:0]                 r_cnt;
  logic                        w_push, w_pop;

  assign full     = (r_cnt == (AW+1)'(DEPTH));
  assign empty    = (r_cnt == '0);
  assign w_push   = push && !full;
  assign w_pop    = pop && !empty;
  assign pop_data = r_mem[r_rd];

  // storage is cleared on reset so pop_data is never X while empty
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= push_data;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_pop) r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// File: rtl/glb_pe_bus_receiver.sv
// Per-PE bus receiver: claims words tagged with this column ID and routes them by type into three FIFOs.
module glb_pe_bus_receiver
  import glb_bus_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_COL    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16,
  localparam int IDW       = id_width(NUM_COL)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_id_we,
  input  logic [IDW-1:0]          cfg_id,
  glb_pe_bus_receiver_if.slave    bus,
  output logic                    ifmap_valid,
  input  logic                    ifmap_ready,
  output logic [DATA_WIDTH-1:0]   ifmap_data,
  output logic                    fltr_valid,
  input  logic                    fltr_ready,
  output logic [DATA_WIDTH-1:0]   fltr_data,
  output logic                    psum_valid,
  input  logic                    psum_ready,
  output logic [2*DATA_WIDTH-1:0] psum_data,
  output logic [IDW-1:0]          id_q,
  output logic [CNT_WIDTH-1:0]    acc_cnt,
  output logic                    err_type
);
  logic [IDW-1:0]       r_id;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_err;
  bus_type_e            w_type;
  logic                 w_match, w_hit, w_ready, w_accept, w_sel_full;
  logic                 w_if_full, w_fl_full, w_ps_full;
  logic                 w_if_empty, w_fl_empty, w_ps_empty;

  assign w_type  = bus_type_e'(bus.bus_type);
  assign w_match = (bus.bus_tag == r_id);
  assign w_hit   = bus.bus_valid && w_match;

  always_comb begin
    w_sel_full = 1'b0;
    case (w_type)
      BT_IFMAP: w_sel_full = w_if_full;
      BT_FLTR:  w_sel_full = w_fl_full;
      BT_PSUM:  w_sel_full = w_ps_full;
      default:  w_sel_full = 1'b0;
    endcase
  end

  // READY ignores bus_valid: foreign tags and reserved types always pass
  assign w_ready       = !w_match || (w_type == BT_RSVD) || !w_sel_full;
  assign bus.bus_ready = w_ready;
  assign w_accept      = w_hit && w_ready && (w_type != BT_RSVD);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_id  <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (cfg_id_we) r_id <= cfg_id;
      if (w_accept)  r_cnt <= r_cnt + CNT_WIDTH'(1);
      if (w_hit && (w_type == BT_RSVD)) r_err <= 1'b1;
    end
  end

  glb_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_ifmap (
    .clk(clk), .rst(rst),
    .push(w_accept && (w_type == BT_IFMAP)), .push_data(bus.bus_data[DATA_WIDTH-1:0]), .full(w_if_full),
    .pop(ifmap_ready), .pop_data(ifmap_data), .empty(w_if_empty)
  );

  glb_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fltr (
    .clk(clk), .rst(rst),
    .push(w_accept && (w_type == BT_FLTR)), .push_data(bus.bus_data[DATA_WIDTH-1:0]), .full(w_fl_full),
    .pop(fltr_ready), .pop_data(fltr_data), .empty(w_fl_empty)
  );

  glb_sync_fifo #(.WIDTH(2*DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_psum (
    .clk(clk), .rst(rst),
    .push(w_accept && (w_type == BT_PSUM)), .push_data(bus.bus_data), .full(w_ps_full),
    .pop(psum_ready), .pop_data(psum_data), .empty(w_ps_empty)
  );

  assign ifmap_valid = !w_if_empty;
  assign fltr_valid  = !w_fl_empty;
  assign psum_valid  = !w_ps_empty;
  assign id_q        = r_id;
  assign acc_cnt     = r_cnt;
  assign err_type    = r_err;
endmodule

// File: tb/tb_glb_pe_bus_receiver.sv
// Bench for glb_pe_bus_receiver: vector table plus per-stream scoreboard queues checked every cycle.
module tb_glb_pe_bus_receiver;
  localparam int DW    = 16;
  localparam int NC    = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_id_we;
  logic [1:0]  cfg_id;
  logic        ifmap_valid, ifmap_ready, fltr_valid, fltr_ready, psum_valid, psum_ready;
  logic [15:0] ifmap_data, fltr_data;
  logic [31:0] psum_data;
  logic [1:0]  id_q;
  logic [15:0] acc_cnt;
  logic        err_type;

  glb_pe_bus_receiver_if #(.DATA_WIDTH(DW), .NUM_COL(NC)) bif ();

  glb_pe_bus_receiver #(.DATA_WIDTH(DW), .NUM_COL(NC), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .cfg_id_we(cfg_id_we), .cfg_id(cfg_id), .bus(bif.slave),
    .ifmap_valid(ifmap_valid), .ifmap_ready(ifmap_ready), .ifmap_data(ifmap_data),
    .fltr_valid(fltr_valid), .fltr_ready(fltr_ready), .fltr_data(fltr_data),
    .psum_valid(psum_valid), .psum_ready(psum_ready), .psum_data(psum_data),
    .id_q(id_q), .acc_cnt(acc_cnt), .err_type(err_type)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [1:0]  tag;
    logic [1:0]  typ;
    logic [31:0] data;
    logic [2:0]  rdy;      // {psum, fltr, ifmap}
    logic        exp_brdy;
  } vec_t;

  vec_t        vecs[22];
  logic [31:0] q_if[$], q_fl[$], q_ps[$];
  logic [1:0]  m_id;
  logic [15:0] m_cnt;
  logic        m_err;
  int          n_chk = 0;
  int          n_err = 0;
  logic        tbl_en = 1'b0;
  logic        tbl_exp = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Checks outputs against the model at negedge, then advances the model for the coming edge.
  task automatic cycle();
    logic m_match, exp_br;
    int   sz;
    @(negedge clk);
    m_match = (bif.bus_tag == m_id);
    sz = (bif.bus_type == 2'd0) ? q_if.size() : (bif.bus_type == 2'd1) ? q_fl.size() : q_ps.size();
    exp_br = !m_match || (bif.bus_type == 2'd3) || (sz < DEPTH);
    chk("bus_ready", 32'(bif.bus_ready), 32'(exp_br));
    if (tbl_en) chk("vec bus_ready", 32'(bif.bus_ready), 32'(tbl_exp));
    chk("ifmap_valid", 32'(ifmap_valid), 32'(q_if.size() != 0));
    chk("fltr_valid", 32'(fltr_valid), 32'(q_fl.size() != 0));
    chk("psum_valid", 32'(psum_valid), 32'(q_ps.size() != 0));
    if (q_if.size() != 0) chk("ifmap_data", 32'(ifmap_data), 32'(q_if[0][15:0]));
    if (q_fl.size() != 0) chk("fltr_data", 32'(fltr_data), 32'(q_fl[0][15:0]));
    if (q_ps.size() != 0) chk("psum_data", psum_data, q_ps[0]);
    chk("acc_cnt", 32'(acc_cnt), 32'(m_cnt));
    chk("err_type", 32'(err_type), 32'(m_err));
    chk("id_q", 32'(id_q), 32'(m_id));
    if (rst) begin
      q_if.delete(); q_fl.delete(); q_ps.delete();
      m_id = '0; m_cnt = '0; m_err = 1'b0;
    end else begin
      if (q_if.size() != 0 && ifmap_ready) void'(q_if.pop_front());
      if (q_fl.size() != 0 && fltr_ready)  void'(q_fl.pop_front());
      if (q_ps.size() != 0 && psum_ready)  void'(q_ps.pop_front());
      if (bif.bus_valid && m_match && exp_br && bif.bus_type != 2'd3) begin
        case (bif.bus_type)
          2'd0:    q_if.push_back(bif.bus_data);
          2'd1:    q_fl.push_back(bif.bus_data);
          default: q_ps.push_back(bif.bus_data);
        endcase
        m_cnt = m_cnt + 16'd1;
      end
      if (bif.bus_valid && m_match && bif.bus_type == 2'd3) m_err = 1'b1;
      if (cfg_id_we) m_id = cfg_id;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] tag, input logic [1:0] typ,
                       input logic [31:0] data, input logic [2:0] rdy);
    bif.bus_valid = v; bif.bus_tag = tag; bif.bus_type = typ; bif.bus_data = data;
    {psum_ready, fltr_ready, ifmap_ready} = rdy;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 2'd2, 2'd0, 32'h0001_ABCD, 3'b000, 1'b1};
    vecs[1]  = '{1'b1, 2'd1, 2'd2, 32'h0000_DEAD, 3'b000, 1'b1};
    vecs[2]  = '{1'b1, 2'd1, 2'd2, 32'h0000_DEAD, 3'b000, 1'b1};
    vecs[3]  = '{1'b1, 2'd1, 2'd2, 32'h0000_DEAD, 3'b000, 1'b1};
    vecs[4]  = '{1'b1, 2'd2, 2'd2, 32'h0000_0010, 3'b000, 1'b1};
    vecs[5]  = '{1'b1, 2'd2, 2'd2, 32'h0000_0011, 3'b000, 1'b1};
    vecs[6]  = '{1'b1, 2'd2, 2'd2, 32'h0000_0012, 3'b000, 1'b1};
    vecs[7]  = '{1'b1, 2'd2, 2'd2, 32'h0000_0013, 3'b000, 1'b1};
    vecs[8]  = '{1'b1, 2'd2, 2'd2, 32'h0000_0014, 3'b000, 1'b0};
    vecs[9]  = '{1'b1, 2'd2, 2'd2, 32'h0000_0014, 3'b100, 1'b0};
    vecs[10] = '{1'b1, 2'd2, 2'd2, 32'h0000_0014, 3'b000, 1'b1};
    vecs[11] = '{1'b1, 2'd2, 2'd1, 32'hFFFF_55AA, 3'b000, 1'b1};
    vecs[12] = '{1'b1, 2'd2, 2'd3, 32'h0000_0BAD, 3'b000, 1'b1};
    vecs[13] = '{1'b0, 2'd2, 2'd2, 32'h0000_0000, 3'b000, 1'b0};
    vecs[14] = '{1'b0, 2'd3, 2'd2, 32'h0000_0000, 3'b111, 1'b1};
    vecs[15] = '{1'b0, 2'd3, 2'd2, 32'h0000_0000, 3'b111, 1'b1};
    vecs[16] = '{1'b0, 2'd3, 2'd2, 32'h0000_0000, 3'b111, 1'b1};
    vecs[17] = '{1'b0, 2'd3, 2'd2, 32'h0000_0000, 3'b111, 1'b1};
    vecs[18] = '{1'b0, 2'd3, 2'd2, 32'h0000_0000, 3'b111, 1'b1};
    vecs[19] = '{1'b1, 2'd2, 2'd2, 32'h1234_0020, 3'b100, 1'b1};
    vecs[20] = '{1'b1, 2'd2, 2'd2, 32'h1234_0021, 3'b100, 1'b1};
    vecs[21] = '{1'b0, 2'd3, 2'd2, 32'h0000_0000, 3'b100, 1'b1};

    m_id = '0; m_cnt = '0; m_err = 1'b0;
    rst = 1'b1; cfg_id_we = 1'b0; cfg_id = '0;
    drive(1'b0, 2'd0, 2'd0, 32'h0, 3'b000);
    repeat (2) @(posedge clk);
    #1;
    cycle();
    rst = 1'b0;

    cfg_id_we = 1'b1; cfg_id = 2'd2;
    cycle();
    cfg_id_we = 1'b0;
    chk("id after cfg", 32'(id_q), 32'd2);

    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].v, vecs[i].tag, vecs[i].typ, vecs[i].data, vecs[i].rdy);
      tbl_en = 1'b1; tbl_exp = vecs[i].exp_brdy;
      cycle();
      tbl_en = 1'b0;
      if (i == 0) chk("first ifmap data", 32'(ifmap_data), 32'h0000_ABCD);
      if (i == 12) chk("err set", 32'(err_type), 32'd1);
    end
    chk("err sticky", 32'(err_type), 32'd1);
    chk("acc after table", 32'(acc_cnt), 32'd9);

    // ID write and a matching word in the same cycle: word matches the old ID
    cfg_id_we = 1'b1; cfg_id = 2'd1;
    drive(1'b1, 2'd2, 2'd0, 32'h0000_0077, 3'b000);
    cycle();
    cfg_id_we = 1'b0;
    chk("old id match", 32'(ifmap_valid), 32'd1);
    chk("new id", 32'(id_q), 32'd1);
    drive(1'b1, 2'd1, 2'd0, 32'h0000_0078, 3'b000);
    cycle();

    // reset mid-stream with a matching word on the bus
    drive(1'b1, 2'd1, 2'd0, 32'h0000_0079, 3'b000);
    rst = 1'b1; cfg_id_we = 1'b1; cfg_id = 2'd3;
    cycle();
    rst = 1'b0; cfg_id_we = 1'b0;
    drive(1'b0, 2'd0, 2'd0, 32'h0, 3'b000);
    chk("rst ifmap_valid", 32'(ifmap_valid), 32'd0);
    chk("rst acc_cnt", 32'(acc_cnt), 32'd0);
    chk("rst id_q", 32'(id_q), 32'd0);
    chk("rst err_type", 32'(err_type), 32'd0);
    cycle();

    // stream to wrap acc_cnt through 2^16-1 -> 0
    for (int i = 0; i < 65535; i++) begin
      drive(1'b1, 2'd0, 2'd0, 32'(i), 3'b001);
      cycle();
    end
    chk("acc max", 32'(acc_cnt), 32'h0000_FFFF);
    drive(1'b1, 2'd0, 2'd0, 32'h0000_BEEF, 3'b001);
    cycle();
    chk("acc wrap", 32'(acc_cnt), 32'd0);
    drive(1'b0, 2'd0, 2'd0, 32'h0, 3'b001);
    cycle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
